// File: rtl/ls193_counter.sv
// 74LS193 4-bit synchronous up/down counter with load, clear and carry/borrow outputs.
// Optional LS193_SYNC_INPUTS_EN adds two-flop synchronizers on up, dn, load_n and clr.
module ls193_counter #(
   parameter logic [3:0] INIT = 4'b0000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       up,
   input  logic       dn,
   input  logic       load_n,
   input  logic       clr,
   input  logic [3:0] d,
   output logic [3:0] q,
   output logic       co_n,
   output logic       bo_n
);

   logic up_i;
   logic dn_i;
   logic load_n_i;
   logic clr_i;

`ifdef LS193_SYNC_INPUTS_EN
   logic [1:0] up_s;
   logic [1:0] dn_s;
   logic [1:0] load_n_s;
   logic [1:0] clr_s;

   // Synchronizer idle levels match "no edge, no load, no clear".
   always_ff @(posedge clk) begin
      if (reset) begin
         up_s     <= 2'b11;
         dn_s     <= 2'b11;
         load_n_s <= 2'b11;
         clr_s    <= 2'b00;
      end else begin
         up_s     <= {up_s[0], up};
         dn_s     <= {dn_s[0], dn};
         load_n_s <= {load_n_s[0], load_n};
         clr_s    <= {clr_s[0], clr};
      end
   end

   assign up_i     = up_s[1];
   assign dn_i     = dn_s[1];
   assign load_n_i = load_n_s[1];
   assign clr_i    = clr_s[1];
`else
   assign up_i     = up;
   assign dn_i     = dn;
   assign load_n_i = load_n;
   assign clr_i    = clr;
`endif

   logic up_q;
   logic dn_q;
   logic up_rise;
   logic dn_rise;

   assign up_rise = up_i & ~up_q;
   assign dn_rise = dn_i & ~dn_q;

   // Edge history resets high so a line held high through reset never counts.
   always_ff @(posedge clk) begin
      if (reset) begin
         q    <= INIT;
         up_q <= 1'b1;
         dn_q <= 1'b1;
      end else begin
         up_q <= up_i;
         dn_q <= dn_i;
         if (clr_i)
            q <= 4'd0;
         else if (!load_n_i)
            q <= d;
         else if (up_rise && !dn_rise && dn_i)
            q <= q + 4'd1;
         else if (dn_rise && !up_rise && up_i)
            q <= q - 4'd1;
      end
   end

   assign co_n = ~((q == 4'd15) & ~up_i);
   assign bo_n = ~((q == 4'd0) & ~dn_i);

endmodule
